rf_wport_arbiter: RTL and testbench



---
 rtl/rf_wport_arbiter.sv | 123 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and a one-entry LU result
// buffer. WB wins by default and an age counter forces LU after MAX_WAIT lost cycles.
// Optional golden-trace outputs are enabled by defining DEBUG_TRACE_EN.
module rf_wport_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_pc,
  input  logic [3:0]        wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [31:0]       lu_pc,
  input  logic [3:0]        lu_we,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic [3:0]        rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              lu_pending,
  output logic [ADDR_W-1:0] lu_pend_addr
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  localparam logic [CNT_W-1:0] MAX_AGE = CNT_W'(MAX_WAIT);

  logic              buf_v;
  logic [3:0]        buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [CNT_W-1:0]  age;

  logic force_lu;
  logic gnt_wb;
  logic gnt_lu;
  logic capture;

  assign force_lu = buf_v && (age >= MAX_AGE);
  assign gnt_wb   = wb_valid && !force_lu;
  assign gnt_lu   = buf_v && !gnt_wb;
  assign wb_ready = !force_lu;
  // The buffer may refill in the same cycle its old result drains to the regfile.
  assign lu_ready = !buf_v || gnt_lu;
  assign capture  = lu_valid && lu_ready;

  assign lu_pending   = buf_v;
  assign lu_pend_addr = buf_v ? buf_addr : '0;

  // NOTE: every output is defaulted before the branches so no latch is inferred.
  always_comb begin
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (gnt_wb) begin
      rf_we    = (wb_waddr == '0) ? 4'b0000 : wb_we;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (gnt_lu) begin
      rf_we    = (buf_addr == '0) ? 4'b0000 : buf_we;
      rf_waddr = buf_addr;
      rf_wdata = buf_data;
    end
  end

  // NOTE: state uses non-blocking assignments; the small buffer is reset explicitly
  // so lu_pend_addr and trace outputs never carry stale data after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_v    <= 1'b0;
      buf_we   <= '0;
      buf_addr <= '0;
      buf_data <= '0;
      age      <= '0;
    end else if (capture) begin
      buf_v    <= 1'b1;
      buf_we   <= lu_we;
      buf_addr <= lu_waddr;
      buf_data <= lu_wdata;
      age      <= '0;
    end else if (gnt_lu) begin
      buf_v <= 1'b0;
      age   <= '0;
    end else if (buf_v && (age < MAX_AGE)) begin
      age <= age + CNT_W'(1);
    end
  end

`ifdef DEBUG_TRACE_EN
  logic [31:0] buf_pc;

  always_ff @(posedge clk) begin
    if (reset)        buf_pc <= '0;
    else if (capture) buf_pc <= lu_pc;
  end

  always_comb begin
    debug_wb_pc = '0;
    if (gnt_wb)      debug_wb_pc = wb_pc;
    else if (gnt_lu) debug_wb_pc = buf_pc;
  end

  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^{wb_pc, lu_pc};
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus a random phase, with
// expected port values pushed to a scoreboard queue and popped when outputs settle.
module tb_rf_wport_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_pc;
  logic [3:0]        wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              lu_valid;
  logic              lu_ready;
  logic [31:0]       lu_pc;
  logic [3:0]        lu_we;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic [3:0]        rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              lu_pending;
  logic [ADDR_W-1:0] lu_pend_addr;

  rf_wport_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_pc(lu_pc), .lu_we(lu_we),
    .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lu_pending(lu_pending), .lu_pend_addr(lu_pend_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wb_rdy;
    logic              lu_rdy;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state of the LU buffer as seen from the ports.
  logic              m_v;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_age;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("rf_we",        32'(rf_we),        32'(e.we));
    check("rf_waddr",     32'(rf_waddr),     32'(e.addr));
    check("rf_wdata",     rf_wdata,          e.data);
    check("wb_ready",     32'(wb_ready),     32'(e.wb_rdy));
    check("lu_ready",     32'(lu_ready),     32'(e.lu_rdy));
    check("lu_pending",   32'(lu_pending),   32'(e.pend));
    check("lu_pend_addr", 32'(lu_pend_addr), 32'(e.pend_addr));
  endtask

  task automatic step(input logic rst,
                      input logic wv, input logic [3:0] wwe, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd,
                      input logic lv, input logic [3:0] lwe, input logic [ADDR_W-1:0] la,
                      input logic [DATA_W-1:0] ld);
    exp_t e;
    logic frc, take_wb, take_lu;
    @(negedge clk);
    reset = rst;
    wb_valid = wv; wb_we = wwe; wb_waddr = wa; wb_wdata = wd; wb_pc = $urandom;
    lu_valid = lv; lu_we = lwe; lu_waddr = la; lu_wdata = ld; lu_pc = $urandom;

    frc     = m_v && (m_age >= MAX_WAIT);
    take_wb = wv && !frc;
    take_lu = m_v && !take_wb;
    e = '0;
    if (take_wb) begin
      e.we = (wa == 0) ? 4'h0 : wwe; e.addr = wa; e.data = wd;
    end else if (take_lu) begin
      e.we = (m_addr == 0) ? 4'h0 : m_we; e.addr = m_addr; e.data = m_data;
    end
    e.wb_rdy    = !frc;
    e.lu_rdy    = !m_v || take_lu;
    e.pend      = m_v;
    e.pend_addr = m_v ? m_addr : '0;
    exp_q.push_back(e);

    #1 compare_outputs();

    if (rst) begin
      m_v = 1'b0; m_we = '0; m_addr = '0; m_data = '0; m_age = 0;
    end else if (lv && e.lu_rdy) begin
      m_v = 1'b1; m_we = lwe; m_addr = la; m_data = ld; m_age = 0;
    end else if (take_lu) begin
      m_v = 1'b0; m_age = 0;
    end else if (m_v && m_age < MAX_WAIT) begin
      m_age++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 1'b0; wb_we = '0; wb_waddr = '0; wb_wdata = '0; wb_pc = '0;
    lu_valid = 1'b0; lu_we = '0; lu_waddr = '0; lu_wdata = '0; lu_pc = '0;
    m_v = 1'b0; m_we = '0; m_addr = '0; m_data = '0; m_age = 0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    check("rst_rf_we", 32'(rf_we), 32'h0);
    check("rst_lu_ready", 32'(lu_ready), 32'h1);

    // WB only, zero-latency grant
    step(1'b0, 1'b1, 4'hF, 5'd5, 32'h1234, 1'b0, 4'h0, '0, '0);
    check("t1_rf_we", 32'(rf_we), 32'hF);
    check("t1_rf_waddr", 32'(rf_waddr), 32'd5);
    check("t1_wb_ready", 32'(wb_ready), 32'h1);

    // LU only: captured, written next cycle, then empty
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 4'hF, 5'd7, 32'hBEEF);
    check("t2_lu_ready", 32'(lu_ready), 32'h1);
    idle();
    check("t2_pend", 32'(lu_pending), 32'h1);
    check("t2_pend_addr", 32'(lu_pend_addr), 32'd7);
    check("t2_rf_waddr", 32'(rf_waddr), 32'd7);
    check("t2_rf_wdata", rf_wdata, 32'hBEEF);
    idle();
    check("t2_drained", 32'(lu_pending), 32'h0);

    // Aging: WB wins MAX_WAIT cycles, then LU is forced, then WB again
    step(1'b0, 1'b1, 4'hF, 5'd3, 32'hA0, 1'b1, 4'h3, 5'd9, 32'hC0DE);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(1'b0, 1'b1, 4'hF, 5'd3, 32'hA1 + 32'(i), 1'b0, 4'h0, '0, '0);
      check("t3_wb_wins", 32'(rf_waddr), 32'd3);
    end
    step(1'b0, 1'b1, 4'hF, 5'd3, 32'hA8, 1'b0, 4'h0, '0, '0);
    check("t3_forced_wb_ready", 32'(wb_ready), 32'h0);
    check("t3_forced_addr", 32'(rf_waddr), 32'd9);
    check("t3_forced_we", 32'(rf_we), 32'h3);
    step(1'b0, 1'b1, 4'hF, 5'd3, 32'hA8, 1'b0, 4'h0, '0, '0);
    check("t3_wb_again", 32'(rf_waddr), 32'd3);

    // Drain and refill in the same cycle
    step(1'b0, 1'b1, 4'hF, 5'd2, 32'h22, 1'b1, 4'hF, 5'd10, 32'h1010);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 4'hF, 5'd11, 32'h1111);
    check("t4_old_written", 32'(rf_waddr), 32'd10);
    check("t4_new_accepted", 32'(lu_ready), 32'h1);
    step(1'b0, 1'b1, 4'hF, 5'd4, 32'h44, 1'b0, 4'h0, '0, '0);
    check("t4_new_pend_addr", 32'(lu_pend_addr), 32'd11);
    for (int i = 0; i < MAX_WAIT; i++) step(1'b0, 1'b1, 4'hF, 5'd4, 32'h45, 1'b0, 4'h0, '0, '0);
    check("t4_age_restart", 32'(rf_waddr), 32'd11);

    // r0 never written, grant still consumed
    step(1'b0, 1'b1, 4'hF, 5'd0, 32'hDEAD, 1'b0, 4'h0, '0, '0);
    check("t5_rf_we", 32'(rf_we), 32'h0);
    check("t5_wb_ready", 32'(wb_ready), 32'h1);

    // Reset discards a buffered result that never got the port
    step(1'b0, 1'b1, 4'hF, 5'd6, 32'h66, 1'b1, 4'hF, 5'd12, 32'h1212);
    step(1'b1, 1'b1, 4'hF, 5'd6, 32'h67, 1'b0, 4'h0, '0, '0);
    check("t6_wb_holds_port", 32'(rf_waddr), 32'd6);
    idle();
    check("t6_pend_cleared", 32'(lu_pending), 32'h0);
    check("t6_no_lu_write", 32'(rf_we), 32'h0);

    // Random traffic, small address range so r0 and collisions occur
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 2) == 0), 4'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
